// File: rtl/assoc_set_fsm.sv
// rtl/assoc_set_fsm.sv - N-way set-associative cache set with writeback/refill and flush FSM
module assoc_set_fsm #(
    parameter int TAG_WIDTH    = 22,
    parameter int OFFSET_WIDTH = 4,
    parameter int SET_SIZE     = 4,
    parameter int REPLACE_MODE = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        req_ready_o,
    output logic [31:0] req_rdata_o,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int WORDS  = 2 ** (OFFSET_WIDTH - 2);
    localparam int WSEL_W = OFFSET_WIDTH - 2;
    localparam int IDX_W  = 32 - TAG_WIDTH - OFFSET_WIDTH;
    localparam int WAY_W  = $clog2(SET_SIZE);
    localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(WORDS - 1);
    localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(SET_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_FLUSH_SCAN} state_t;

    state_t                state_q;
    logic [SET_SIZE-1:0]   valid_q, dirty_q;
    logic [TAG_WIDTH-1:0]  tag_q [SET_SIZE];
    logic [31:0]           data_q [SET_SIZE][WORDS];
    logic [WAY_W-1:0]      age_q [SET_SIZE];
    logic [WAY_W-1:0]      fifo_q, victim_q, scan_q;
    logic [WSEL_W-1:0]     cnt_q;
    logic [TAG_WIDTH-1:0]  ltag_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  flushing_q;
    logic [15:0]           lfsr_q;

    logic [TAG_WIDTH-1:0]  req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WSEL_W-1:0]     req_word;
    logic                  unused_bits;
    logic [SET_SIZE-1:0]   hit_vec;
    logic [WAY_W-1:0]      hit_way, inv_way, lru_way, pol_way, vict, touch_way;
    logic                  hit_any, hit_fire, inv_found, fill_last, touch_en, lfsr_fb;

    assign req_tag     = req_addr_i[31 -: TAG_WIDTH];
    assign req_idx     = req_addr_i[OFFSET_WIDTH +: IDX_W];
    assign req_word    = req_addr_i[2 +: WSEL_W];
    assign unused_bits = ^req_addr_i[1:0];
    assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < SET_SIZE; w++) begin
            if (valid_q[w] && (tag_q[w] == req_tag)) begin
                hit_vec[w] = 1'b1;
                hit_way    = WAY_W'(w);
            end
        end
    end

    assign hit_any  = |hit_vec;
    assign hit_fire = (state_q == S_IDLE) && req_valid_i && !flush_i && hit_any;

    // Empty ways are always consumed first; the policy only picks among full ways.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = SET_SIZE - 1; w >= 0; w--) begin
            if (!valid_q[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        for (int w = 0; w < SET_SIZE; w++) begin
            if (age_q[w] == LAST_WAY) lru_way = WAY_W'(w);
        end
        case (REPLACE_MODE)
            1:       pol_way = fifo_q;
            2:       pol_way = lfsr_q[WAY_W-1:0];
            default: pol_way = lru_way;
        endcase
        vict = inv_found ? inv_way : pol_way;
    end

    assign fill_last = (state_q == S_FILL) && mem_ready_i && (cnt_q == LAST_WORD);
    assign touch_en  = hit_fire || fill_last;
    assign touch_way = fill_last ? victim_q : hit_way;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            fifo_q     <= '0;
            victim_q   <= '0;
            scan_q     <= '0;
            cnt_q      <= '0;
            ltag_q     <= '0;
            idx_q      <= '0;
            flushing_q <= 1'b0;
            lfsr_q     <= 16'h0001;
            for (int w = 0; w < SET_SIZE; w++) begin
                age_q[w] <= WAY_W'(w);
                tag_q[w] <= '0;
            end
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
            if (touch_en) begin
                for (int w = 0; w < SET_SIZE; w++) begin
                    if (WAY_W'(w) == touch_way)
                        age_q[w] <= '0;
                    else if (age_q[w] < age_q[touch_way])
                        age_q[w] <= age_q[w] + WAY_W'(1);
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (flush_i) begin
                        flushing_q <= 1'b1;
                        scan_q     <= '0;
                        idx_q      <= req_idx;
                        state_q    <= S_FLUSH_SCAN;
                    end else if (req_valid_i) begin
                        if (hit_any) begin
                            if (req_write_i) dirty_q[hit_way] <= 1'b1;
                        end else begin
                            victim_q <= vict;
                            ltag_q   <= req_tag;
                            idx_q    <= req_idx;
                            cnt_q    <= '0;
                            state_q  <= (valid_q[vict] && dirty_q[vict]) ? S_WB : S_FILL;
                        end
                    end
                end
                S_WB: begin
                    if (mem_ready_i) begin
                        if (cnt_q == LAST_WORD) begin
                            dirty_q[victim_q] <= 1'b0;
                            cnt_q             <= '0;
                            state_q           <= flushing_q ? S_FLUSH_SCAN : S_FILL;
                        end else begin
                            cnt_q <= cnt_q + WSEL_W'(1);
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ready_i) begin
                        if (cnt_q == LAST_WORD) begin
                            valid_q[victim_q] <= 1'b1;
                            dirty_q[victim_q] <= 1'b0;
                            tag_q[victim_q]   <= ltag_q;
                            fifo_q            <= fifo_q + WAY_W'(1);
                            cnt_q             <= '0;
                            state_q           <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + WSEL_W'(1);
                        end
                    end
                end
                S_FLUSH_SCAN: begin
                    // A written-back way returns here clean, so the else branch then retires it.
                    if (valid_q[scan_q] && dirty_q[scan_q]) begin
                        victim_q <= scan_q;
                        cnt_q    <= '0;
                        state_q  <= S_WB;
                    end else begin
                        valid_q[scan_q] <= 1'b0;
                        if (scan_q == LAST_WAY) begin
                            flushing_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            scan_q <= scan_q + WAY_W'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (hit_fire && req_write_i) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be_i[b]) data_q[hit_way][req_word][8*b +: 8] <= req_wdata_i[8*b +: 8];
            end
        end
        if ((state_q == S_FILL) && mem_ready_i) data_q[victim_q][cnt_q] <= mem_rdata_i;
    end

    assign req_ready_o = hit_fire;
    assign req_rdata_o = data_q[hit_way][req_word];
    assign busy_o      = (state_q != S_IDLE);
    assign mem_req_o   = (state_q == S_WB) || (state_q == S_FILL);
    assign mem_we_o    = (state_q == S_WB);
    assign mem_addr_o  = {(state_q == S_WB) ? tag_q[victim_q] : ltag_q, idx_q, cnt_q, 2'b00};
    assign mem_wdata_o = data_q[victim_q][cnt_q];

    assert property (@(posedge clk_i) disable iff (!rst_i) req_valid_i |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_assoc_set_fsm.sv
// tb/tb_assoc_set_fsm.sv - randomized self-checking bench for assoc_set_fsm (LRU and FIFO instances)
module tb_assoc_set_fsm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        flush [2];
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready [2];
    logic [31:0] req_rdata [2];
    logic        busy [2], mem_req [2], mem_we [2], mem_ready [2];
    logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];

    int checks = 0;
    int failures = 0;
    bit stall = 1'b0;

    logic [31:0] mem [logic [31:0]];
    logic [64:0] log_q [$];
    logic [64:0] exp_q [$];

    bit          mv [2][4];
    bit          md [2][4];
    logic [21:0] mt [2][4];
    logic [31:0] mdat [2][4][4];
    int          lru_q [$];
    int          fptr;

    always #5 clk = ~clk;

    assoc_set_fsm #(.REPLACE_MODE(0)) dut_lru (
        .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid[0]), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .req_ready_o(req_ready[0]), .req_rdata_o(req_rdata[0]), .flush_i(flush[0]),
        .busy_o(busy[0]), .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]),
        .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_ready_i(mem_ready[0]), .mem_rdata_i(mem_rdata[0]));

    assoc_set_fsm #(.REPLACE_MODE(1)) dut_fifo (
        .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid[1]), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .req_ready_o(req_ready[1]), .req_rdata_o(req_rdata[1]), .flush_i(flush[1]),
        .busy_o(busy[1]), .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]),
        .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_ready_i(mem_ready[1]), .mem_rdata_i(mem_rdata[1]));

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    // Memory side: random acceptance delay, refill data from the memory image.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mem_ready[i] = mem_req[i] && !stall && ($urandom_range(0, 3) != 0);
            mem_rdata[i] = mem_ready[i] ? memrd(mem_addr[i]) : $urandom;
        end
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1 && mem_req[0] === 1'b1 && mem_ready[0] === 1'b1) begin
            if (mem_we[0]) mem[mem_addr[0]] = mem_wdata[0];
            log_q.push_back({mem_we[0], mem_addr[0], mem_we[0] ? mem_wdata[0] : mem_rdata[0]});
        end
    end

    function automatic void model_reset();
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 4; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
            end
        lru_q.delete();
        for (int w = 0; w < 4; w++) lru_q.push_back(w);
        fptr = 0;
    endfunction

    // LRU kept as a recency list: front = most recently used, back = victim.
    function automatic void touch(input int sel, input int w);
        if (sel == 0) begin
            for (int k = 0; k < lru_q.size(); k++)
                if (lru_q[k] == w) begin
                    lru_q.delete(k);
                    break;
                end
            lru_q.push_front(w);
        end
    endfunction

    function automatic void model_access(input int sel, input bit wr, input logic [31:0] a,
                                         input logic [31:0] wd, input logic [3:0] be,
                                         output bit miss, output logic [31:0] rd);
        logic [21:0] tag;
        logic [5:0]  idx;
        logic [31:0] ad;
        int ws, way, v;
        tag = a[31:10];
        idx = a[9:4];
        ws  = int'(a[3:2]);
        way = -1;
        exp_q.delete();
        for (int w = 0; w < 4; w++) if (mv[sel][w] && mt[sel][w] == tag) way = w;
        miss = (way < 0);
        if (miss) begin
            v = -1;
            for (int w = 3; w >= 0; w--) if (!mv[sel][w]) v = w;
            if (v < 0) v = (sel == 0) ? lru_q[$] : fptr;
            if (mv[sel][v] && md[sel][v])
                for (int i = 0; i < 4; i++)
                    exp_q.push_back({1'b1, mt[sel][v], idx, 2'(i), 2'b00, mdat[sel][v][i]});
            for (int i = 0; i < 4; i++) begin
                ad = {tag, idx, 2'(i), 2'b00};
                mdat[sel][v][i] = memrd(ad);
                exp_q.push_back({1'b0, ad, mdat[sel][v][i]});
            end
            mv[sel][v] = 1'b1;
            md[sel][v] = 1'b0;
            mt[sel][v] = tag;
            touch(sel, v);
            if (sel == 1) fptr = (fptr + 1) % 4;
            way = v;
        end
        rd = mdat[sel][way][ws];
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdat[sel][way][ws][8*b +: 8] = wd[8*b +: 8];
            md[sel][way] = 1'b1;
        end
        touch(sel, way);
    endfunction

    function automatic void model_flush(input int sel, input logic [31:0] a);
        exp_q.delete();
        for (int w = 0; w < 4; w++) begin
            if (mv[sel][w] && md[sel][w])
                for (int i = 0; i < 4; i++)
                    exp_q.push_back({1'b1, mt[sel][w], a[9:4], 2'(i), 2'b00, mdat[sel][w][i]});
            mv[sel][w] = 1'b0;
            md[sel][w] = 1'b0;
        end
    endfunction

    task automatic drive(input int sel, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output int cyc);
        bit got = 1'b0;
        log_q.delete();
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        req_valid[sel] = 1'b1;
        cyc = -1;
        rd  = '0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (req_ready[sel] === 1'b1) begin
                rd  = req_rdata[sel];
                cyc = c;
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid[sel] = 1'b0;
    endtask

    task automatic drive_flush(input int sel, input logic [31:0] a, output int cyc);
        bit got = 1'b0;
        log_q.delete();
        req_addr = a;
        flush[sel] = 1'b1;
        @(posedge clk);
        #1;
        flush[sel] = 1'b0;
        cyc = -1;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (busy[sel] === 1'b0) begin
                cyc = c;
                got = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        flush[0] = 1'b0;
        flush[1] = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] taddr(input int k);
        return 32'((k + 1) * 32'h400 + 32'h40);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        flush[0] = 1'b0;
        flush[1] = 1'b0;
        req_write = 1'b0;
        req_addr = 32'h40;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++; if (busy[s] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", s, busy[s]); end
            checks++; if (mem_req[s] !== 1'b0) begin failures++; $display("FAIL reset_mem_req[%0d] got=%b exp=0", s, mem_req[s]); end
            checks++; if (mem_we[s] !== 1'b0) begin failures++; $display("FAIL reset_mem_we[%0d] got=%b exp=0", s, mem_we[s]); end
            checks++; if (req_ready[s] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d] got=%b exp=0", s, req_ready[s]); end
        end
        apply_reset();
    endtask

    task automatic test_load_fill();
        bit em; logic [31:0] erd, rd; int cyc;
        model_access(0, 1'b0, 32'h40, 32'h0, 4'h0, em, erd);
        drive(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, cyc);
        checks++; if (cyc < 1) begin failures++; $display("FAIL fill_miss cycles=%0d exp>0", cyc); end
        checks++; if (log_q.size() != 4) begin failures++; $display("FAIL fill_count got=%0d exp=4", log_q.size()); end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i][64:32] !== {1'b0, 32'(32'h40 + 4 * i)}) begin
                failures++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, log_q[i][63:32], 32'h40 + 4 * i);
            end
        end
        checks++; if (rd !== memrd(32'h40)) begin failures++; $display("FAIL fill_rdata got=%h exp=%h", rd, memrd(32'h40)); end
        model_access(0, 1'b0, 32'h40, 32'h0, 4'h0, em, erd);
        drive(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, cyc);
        checks++; if (cyc != 0) begin failures++; $display("FAIL hit_latency got=%0d exp=0", cyc); end
        checks++; if (rd !== erd) begin failures++; $display("FAIL hit_rdata got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_store_merge();
        bit em; logic [31:0] erd, rd; int cyc;
        mem[32'h0001_0000] = 32'hAABBCCDD;
        model_access(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, em, erd);
        drive(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, rd, cyc);
        checks++; if (rd !== 32'hAABBCCDD) begin failures++; $display("FAIL st_preload got=%h exp=aabbccdd", rd); end
        model_access(0, 1'b1, 32'h0001_0000, 32'hDEADBEEF, 4'b0011, em, erd);
        drive(0, 1'b1, 32'h0001_0000, 32'hDEADBEEF, 4'b0011, rd, cyc);
        checks++; if (cyc != 0) begin failures++; $display("FAIL st_hit cycles=%0d exp=0", cyc); end
        model_access(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, em, erd);
        drive(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, rd, cyc);
        checks++; if (rd !== 32'hAABBBEEF) begin failures++; $display("FAIL st_merge got=%h exp=aabbbeef", rd); end
        model_flush(0, 32'h0001_0000);
        drive_flush(0, 32'h0001_0000, cyc);
        checks++; if (log_q.size() != 4) begin failures++; $display("FAIL st_dirty_wb count=%0d exp=4", log_q.size()); end
        checks++;
        if (log_q.size() < 1 || log_q[0] !== {1'b1, 32'h0001_0000, 32'hAABBBEEF}) begin
            failures++; $display("FAIL st_dirty_wb0 got=%h exp=%h", log_q.size() ? log_q[0] : 65'h0, {1'b1, 32'h0001_0000, 32'hAABBBEEF});
        end
    endtask

    task automatic test_lru();
        int seq [6] = '{0, 1, 2, 3, 0, 4};
        bit em; logic [31:0] erd, rd; int cyc; bit wr;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            wr = (k == 1);
            model_access(0, wr, taddr(seq[k]), 32'h1234_5678, 4'hF, em, erd);
            drive(0, wr, taddr(seq[k]), 32'h1234_5678, 4'hF, rd, cyc);
            checks++; if ((cyc > 0) !== em || cyc < 0) begin failures++; $display("FAIL lru_miss[%0d] cycles=%0d exp_miss=%b", k, cyc, em); end
            if (!wr) begin
                checks++; if (rd !== erd) begin failures++; $display("FAIL lru_rdata[%0d] got=%h exp=%h", k, rd, erd); end
            end
        end
        checks++; if (log_q.size() != 8) begin failures++; $display("FAIL lru_xfers got=%0d exp=8", log_q.size()); end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i][64] !== 1'b1 || log_q[i][63:42] !== taddr(1) >> 10) begin
                failures++; $display("FAIL lru_wb_tag[%0d] got=%h exp_tag=%h", i, log_q[i][64:32], taddr(1) >> 10);
            end
        end
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            checks++; if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL lru_xfer[%0d] got=%h exp=%h", i, log_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_fifo();
        int seq [9]      = '{0, 1, 2, 3, 0, 0, 4, 1, 0};
        bit exp_miss [9] = '{1, 1, 1, 1, 0, 0, 1, 0, 1};
        bit em; logic [31:0] erd, rd; int cyc;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            model_access(1, 1'b0, taddr(seq[k]), 32'h0, 4'h0, em, erd);
            drive(1, 1'b0, taddr(seq[k]), 32'h0, 4'h0, rd, cyc);
            checks++; if ((cyc > 0) !== exp_miss[k] || cyc < 0) begin failures++; $display("FAIL fifo_miss[%0d] cycles=%0d exp_miss=%b", k, cyc, exp_miss[k]); end
            checks++; if (rd !== erd) begin failures++; $display("FAIL fifo_rdata[%0d] got=%h exp=%h", k, rd, erd); end
        end
    endtask

    task automatic test_flush();
        bit em; logic [31:0] erd, rd; int cyc, nwr;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            model_access(0, (k % 2) == 0, taddr(k), 32'hC0DE_0000 + k, 4'hF, em, erd);
            drive(0, (k % 2) == 0, taddr(k), 32'hC0DE_0000 + k, 4'hF, rd, cyc);
        end
        model_flush(0, 32'h0000_0080);
        drive_flush(0, 32'h0000_0080, cyc);
        nwr = 0;
        foreach (log_q[i]) if (log_q[i][64]) nwr++;
        checks++; if (cyc < 0) begin failures++; $display("FAIL flush_done busy=%b exp=0", busy[0]); end
        checks++; if (nwr != 8 || log_q.size() != 8) begin failures++; $display("FAIL flush_writes got=%0d/%0d exp=8", nwr, log_q.size()); end
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            checks++; if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL flush_xfer[%0d] got=%h exp=%h", i, log_q[i], exp_q[i]); end
        end
        for (int k = 0; k < 4; k++) begin
            model_access(0, 1'b0, taddr(k), 32'h0, 4'h0, em, erd);
            drive(0, 1'b0, taddr(k), 32'h0, 4'h0, rd, cyc);
            checks++; if (cyc < 1) begin failures++; $display("FAIL flush_after_miss[%0d] cycles=%0d exp>0", k, cyc); end
        end
    endtask

    task automatic test_reset_mid_fill();
        bit em; logic [31:0] erd, rd; int cyc;
        apply_reset();
        model_access(0, 1'b0, taddr(0), 32'h0, 4'h0, em, erd);
        drive(0, 1'b0, taddr(0), 32'h0, 4'h0, rd, cyc);
        stall = 1'b1;
        req_addr = taddr(5);
        req_write = 1'b0;
        req_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_req[0] !== 1'b1 || mem_we[0] !== 1'b0) begin failures++; $display("FAIL midfill_req got=%b/%b exp=1/0", mem_req[0], mem_we[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req[0] !== 1'b0) begin failures++; $display("FAIL midfill_drop got=%b exp=0", mem_req[0]); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL midfill_busy got=%b exp=0", busy[0]); end
        req_valid[0] = 1'b0;
        apply_reset();
        model_access(0, 1'b0, taddr(0), 32'h0, 4'h0, em, erd);
        drive(0, 1'b0, taddr(0), 32'h0, 4'h0, rd, cyc);
        checks++; if (cyc < 1) begin failures++; $display("FAIL midfill_after_miss cycles=%0d exp>0", cyc); end
    endtask

    task automatic test_random();
        bit em, wr; logic [31:0] erd, rd, a, wd; logic [3:0] be; int cyc;
        apply_reset();
        for (int n = 0; n < 200; n++) begin
            a = {22'($urandom_range(0, 5) * 37 + 3), 6'($urandom), 2'($urandom), 2'b00};
            if ($urandom_range(0, 19) == 0) begin
                model_flush(0, a);
                drive_flush(0, a, cyc);
                checks++; if (cyc < 0) begin failures++; $display("FAIL rnd_flush_done[%0d] busy=%b exp=0", n, busy[0]); end
            end else begin
                wr = $urandom_range(0, 1);
                wd = $urandom;
                be = 4'($urandom);
                model_access(0, wr, a, wd, be, em, erd);
                drive(0, wr, a, wd, be, rd, cyc);
                checks++; if ((cyc > 0) !== em || cyc < 0) begin failures++; $display("FAIL rnd_miss[%0d] cycles=%0d exp_miss=%b", n, cyc, em); end
                if (!wr) begin
                    checks++; if (rd !== erd) begin failures++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", n, rd, erd); end
                end
            end
            checks++; if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_xfers[%0d] got=%0d exp=%0d", n, log_q.size(), exp_q.size()); end
            for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
                checks++; if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_xfer[%0d.%0d] got=%h exp=%h", n, i, log_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        flush[0] = 1'b0;
        flush[1] = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_be = '0;
        model_reset();
        test_reset();
        test_load_fill();
        test_store_merge();
        test_lru();
        test_fifo();
        test_flush();
        test_reset_mid_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
